// File: rtl/adc_spi_cfg.sv
// Configuration sequencer for two octal ADCs: hardware reset, settle, table-driven init frames
// over a shared 3-wire SPI, plus single host writes with SDOUT capture for readback.
module adc_spi_cfg #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned RST_CYCLES  = 40,
    parameter int unsigned WAIT_CYCLES = 200,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned FRAME_BITS  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [7:0]            tbl_idx,
    input  logic [FRAME_BITS-1:0] tbl_word,
    input  logic                  wr_req,
    output logic                  wr_ready,
    input  logic [1:0]            wr_chip_mask,
    input  logic [FRAME_BITS-1:0] wr_word,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            adc_sen,
    output logic                  adc_sclk,
    output logic                  adc_sdata,
    input  logic                  adc_sdout,
    output logic                  adc_reset
);

    localparam int unsigned MaxRw  = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int unsigned CntMax = (MaxRw > 2 * CLK_DIV) ? MaxRw : 2 * CLK_DIV;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned PhLast = 2 * FRAME_BITS + 3;
    localparam int unsigned PhW    = $clog2(PhLast + 1);

    localparam logic [CntW-1:0] RstLast   = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] WaitLast  = CntW'(WAIT_CYCLES - 1);
    localparam logic [CntW-1:0] HalfLast  = CntW'(CLK_DIV - 1);
    localparam logic [PhW-1:0]  PhBitLast = PhW'(2 * FRAME_BITS);
    localparam logic [PhW-1:0]  PhHold    = PhW'(2 * FRAME_BITS + 1);
    localparam logic [PhW-1:0]  PhGap     = PhW'(2 * FRAME_BITS + 2);
    localparam logic [PhW-1:0]  PhEnd     = PhW'(PhLast);
    localparam logic [7:0]      IdxEnd    = 8'(NUM_REGS);

    typedef enum logic [2:0] {StIdle, StRst, StWait, StLoad, StFrame, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [PhW-1:0]          ph_q, ph_d;
    logic [7:0]              idx_q, idx_d;
    logic [FRAME_BITS-1:0]   word_q, word_d;
    logic [1:0]              mask_q, mask_d;
    logic [FRAME_BITS-1:0]   sh_q, sh_d;
    logic [15:0]             rd_data_q, rd_data_d;
    logic                    init_q, init_d;
    logic                    half_end;
    logic [PhW-1:0]          bit_pos;
    logic [FRAME_BITS-1:0]   tx_shift;

    assign tbl_idx = idx_q;
    assign rd_data = rd_data_q;

    // Frame phases of H clks each: 0 setup, 1..2N bit halves (odd low, even high), hold, 2 gap.
    assign half_end = (cnt_q == HalfLast);
    assign bit_pos  = (ph_q == '0) ? '0 : ((ph_q - 1'b1) >> 1);
    assign tx_shift = word_q << bit_pos;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        idx_d     = idx_q;
        word_d    = word_q;
        mask_d    = mask_q;
        sh_d      = sh_q;
        rd_data_d = rd_data_q;
        init_d    = init_q;
        wr_ready  = 1'b0;
        busy      = (state_q != StIdle);
        done      = 1'b0;
        rd_valid  = 1'b0;
        adc_sen   = 2'b11;
        adc_sclk  = 1'b0;
        adc_sdata = 1'b0;
        adc_reset = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d    = '0;
                ph_d     = '0;
                wr_ready = !start && !rst;
                if (start) begin
                    init_d  = 1'b1;
                    state_d = StRst;
                end else if (wr_req && (wr_chip_mask != 2'b00)) begin
                    word_d  = wr_word;
                    mask_d  = wr_chip_mask;
                    init_d  = 1'b0;
                    state_d = StFrame;
                end
            end
            StRst: begin
                adc_reset = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == RstLast) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                idx_d = '0;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WaitLast) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                word_d  = tbl_word;
                mask_d  = 2'b11;
                cnt_d   = '0;
                ph_d    = '0;
                state_d = StFrame;
            end
            StFrame: begin
                if (ph_q <= PhHold) adc_sen = ~mask_q;
                if (ph_q <= PhBitLast) adc_sdata = tx_shift[FRAME_BITS-1];
                adc_sclk = (ph_q != '0) && (ph_q <= PhBitLast) && !ph_q[0];
                rd_valid = (ph_q == PhGap) && (cnt_q == '0);
                cnt_d    = cnt_q + 1'b1;
                if (half_end) begin
                    cnt_d = '0;
                    ph_d  = ph_q + 1'b1;
                    // End of a low half: sclk rises on this edge, so SDOUT is captured here.
                    if (ph_q[0] && (ph_q < PhBitLast)) sh_d = {sh_q[FRAME_BITS-2:0], adc_sdout};
                    // Advance the ROM index early so tbl_word has settled by the next LOAD.
                    if (ph_q == PhHold) begin
                        rd_data_d = sh_q[15:0];
                        if (init_q) idx_d = idx_q + 8'd1;
                    end
                    if (ph_q == PhEnd) begin
                        ph_d = '0;
                        if (!init_q) state_d = StIdle;
                        else if (idx_q == IdxEnd) state_d = StDone;
                        else state_d = StLoad;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                idx_d   = '0;
                init_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ph_q      <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            mask_q    <= '0;
            sh_q      <= '0;
            rd_data_q <= '0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            mask_q    <= mask_d;
            sh_q      <= sh_d;
            rd_data_q <= rd_data_d;
            init_q    <= init_d;
        end
    end

endmodule

// File: tb/tb_adc_spi_cfg.sv
// Bench for adc_spi_cfg: one instance at CLK_DIV=4/NUM_REGS=4 for init and host traffic, one at
// CLK_DIV=1 for the fast-frame corner; SPI traffic is decoded and compared with a frame model.
module tb_adc_spi_cfg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        wr_req = 1'b0;
    logic        use2 = 1'b0;
    logic        adc_sdout = 1'b0;
    logic [1:0]  wr_chip_mask = 2'b00;
    logic [23:0] wr_word = '0;

    logic        req1, req2;
    logic [7:0]  tbl_idx1, tbl_idx2;
    logic [23:0] tbl_word1 = '0;
    logic        wr_ready1, rd_valid1, busy1, done1, sclk1, sdata1, reset1;
    logic        wr_ready2, rd_valid2, busy2, done2, sclk2, sdata2, reset2;
    logic [15:0] rd_data1, rd_data2;
    logic [1:0]  sen1, sen2;

    logic        m_ready, m_sclk, m_sdata, m_rvalid;
    logic [1:0]  m_sen;
    logic [15:0] m_rdata;

    int checks = 0;
    int failures = 0;
    logic [23:0] init_rx [8];

    assign req1     = wr_req & ~use2;
    assign req2     = wr_req & use2;
    assign m_ready  = use2 ? wr_ready2 : wr_ready1;
    assign m_sclk   = use2 ? sclk2 : sclk1;
    assign m_sdata  = use2 ? sdata2 : sdata1;
    assign m_rvalid = use2 ? rd_valid2 : rd_valid1;
    assign m_sen    = use2 ? sen2 : sen1;
    assign m_rdata  = use2 ? rd_data2 : rd_data1;

    always #5 clk = ~clk;

    // Init table ROM with one clock of read latency.
    always @(posedge clk) tbl_word1 <= {8'h10 + tbl_idx1, 16'hA5A0 + {8'h00, tbl_idx1}};

    adc_spi_cfg #(.CLK_DIV(4), .RST_CYCLES(40), .WAIT_CYCLES(200), .NUM_REGS(4), .FRAME_BITS(24))
    dut (
        .clk(clk), .rst(rst), .start(start), .tbl_idx(tbl_idx1), .tbl_word(tbl_word1),
        .wr_req(req1), .wr_ready(wr_ready1), .wr_chip_mask(wr_chip_mask), .wr_word(wr_word),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1), .done(done1), .adc_sen(sen1),
        .adc_sclk(sclk1), .adc_sdata(sdata1), .adc_sdout(adc_sdout), .adc_reset(reset1)
    );

    adc_spi_cfg #(.CLK_DIV(1), .RST_CYCLES(40), .WAIT_CYCLES(200), .NUM_REGS(2), .FRAME_BITS(24))
    dut_fast (
        .clk(clk), .rst(rst), .start(1'b0), .tbl_idx(tbl_idx2), .tbl_word(24'h000000),
        .wr_req(req2), .wr_ready(wr_ready2), .wr_chip_mask(wr_chip_mask), .wr_word(wr_word),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2), .done(done2), .adc_sen(sen2),
        .adc_sclk(sclk2), .adc_sdata(sdata2), .adc_sdout(adc_sdout), .adc_reset(reset2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One host write; edge 0 is the accept edge and every observation at e follows edge e.
    task automatic host_xfer(input logic sel, input logic [1:0] mask, input logic [23:0] word,
                             input logic [23:0] resp, output int cyc, output int lo0,
                             output int lo1, output logic [23:0] rx, output int rises,
                             output int rv_cnt, output logic [15:0] rdat, output int rv_gap);
        int wt;
        int last_lo;
        logic prev_sclk;
        logic [23:0] rsh;
        use2 = sel; cyc = -1; lo0 = 0; lo1 = 0; rx = '0; rises = 0;
        rv_cnt = 0; rdat = '0; rv_gap = -1; last_lo = -100; wt = 0;
        @(negedge clk);
        while (!m_ready && wt < 3000) begin
            @(negedge clk);
            wt++;
        end
        chk("host_ready_before_req", {63'b0, m_ready}, 64'd1);
        if (!m_ready) return;
        wr_chip_mask = mask;
        wr_word      = word;
        wr_req       = 1'b1;
        adc_sdout    = resp[23];
        @(posedge clk);
        prev_sclk = 1'b0;
        for (int e = 0; e < 3000; e++) begin
            @(negedge clk);
            if (e == 0) wr_req = 1'b0;
            if (m_sen != 2'b11) last_lo = e;
            if (!m_sen[0]) lo0++;
            if (!m_sen[1]) lo1++;
            if (m_sclk && !prev_sclk) begin
                rx = {rx[22:0], m_sdata};
                rises++;
            end
            prev_sclk = m_sclk;
            rsh = resp << rises;
            adc_sdout = rsh[23];
            if (m_rvalid) begin
                rv_cnt++;
                rdat   = m_rdata;
                rv_gap = e - last_lo;
            end
            if (m_ready) begin
                cyc = e;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic sel, input logic [1:0] mask,
                               input logic [23:0] word, input logic [23:0] resp, input int ecyc,
                               input int elo0, input int elo1, input logic [23:0] erx,
                               input logic [15:0] erd);
        int cyc, lo0, lo1, rises, rv_cnt, rv_gap;
        logic [23:0] rx;
        logic [15:0] rdat;
        host_xfer(sel, mask, word, resp, cyc, lo0, lo1, rx, rises, rv_cnt, rdat, rv_gap);
        chk({tag, ".ready_latency"}, 64'(cyc), 64'(ecyc));
        chk({tag, ".sen0_low"}, 64'(lo0), 64'(elo0));
        chk({tag, ".sen1_low"}, 64'(lo1), 64'(elo1));
        chk({tag, ".frame_word"}, {40'b0, rx}, {40'b0, erx});
        chk({tag, ".sclk_rises"}, 64'(rises), (mask != 2'b00) ? 64'd24 : 64'd0);
        chk({tag, ".rd_valid_pulses"}, 64'(rv_cnt), (mask != 2'b00) ? 64'd1 : 64'd0);
        if (mask != 2'b00) begin
            chk({tag, ".rd_data"}, {48'b0, rdat}, {48'b0, erd});
            chk({tag, ".rd_valid_after_sen"}, 64'(rv_gap), 64'd1);
        end
    endtask

    // Full init on the main instance; edge 0 is the edge that samples start.
    task automatic run_init(input int restart_e, output int rst_hi, output int nframes,
                            output int both_lo, output int sen_bad, output int ready_cnt,
                            output int done_e);
        logic prev_sclk;
        logic [1:0] prev_sen;
        logic [23:0] rx;
        use2 = 1'b0; rst_hi = 0; nframes = 0; both_lo = 0; sen_bad = 0; ready_cnt = 0;
        done_e = -1; rx = '0; prev_sclk = 1'b0; prev_sen = 2'b11;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int e = 0; e < 4000; e++) begin
            @(negedge clk);
            if (e == 0) start = 1'b0;
            if (e == restart_e) start = 1'b1;
            if (e == restart_e + 1) start = 1'b0;
            if (reset1) rst_hi++;
            if (sen1 == 2'b00) both_lo++;
            else if (sen1 != 2'b11) sen_bad++;
            if (sclk1 && !prev_sclk) rx = {rx[22:0], sdata1};
            if (prev_sen != 2'b11 && sen1 == 2'b11) begin
                if (nframes < 8) init_rx[nframes] = rx;
                nframes++;
                rx = '0;
            end
            prev_sclk = sclk1;
            prev_sen  = sen1;
            if (wr_ready1) ready_cnt++;
            if (done1) begin
                done_e = e;
                break;
            end
        end
    endtask

    typedef struct {
        logic        sel;
        logic [1:0]  mask;
        logic [23:0] word;
        logic [23:0] resp;
        int          cyc;
        int          lo0;
        int          lo1;
        logic [23:0] rx;
        logic [15:0] rd;
    } vec_t;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        int rst_hi, nframes, both_lo, sen_bad, ready_cnt, done_e, dcnt, bcnt, h;
        logic sel;
        logic [1:0] mask;
        logic [23:0] word, resp;

        vecs[0] = '{1'b0, 2'b01, 24'h0A1234, 24'h000000, 208, 200, 0, 24'h0A1234, 16'h0000};
        vecs[1] = '{1'b0, 2'b10, 24'h5A00FF, 24'h00BEEF, 208, 0, 200, 24'h5A00FF, 16'hBEEF};
        vecs[2] = '{1'b0, 2'b11, 24'hFFFFFF, 24'hFFFFFF, 208, 200, 200, 24'hFFFFFF, 16'hFFFF};
        vecs[3] = '{1'b0, 2'b00, 24'h123456, 24'hFFFFFF, 0, 0, 0, 24'h000000, 16'h0000};
        vecs[4] = '{1'b1, 2'b00, 24'h0A1234, 24'h000000, 0, 0, 0, 24'h000000, 16'h0000};
        vecs[5] = '{1'b1, 2'b11, 24'h0A1234, 24'h00BEEF, 52, 50, 50, 24'h0A1234, 16'hBEEF};
        vecs[6] = '{1'b1, 2'b01, 24'h800001, 24'h812345, 52, 50, 0, 24'h800001, 16'h2345};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.adc_sen", {62'b0, sen1}, 64'h3);
        chk("reset.adc_sclk", {63'b0, sclk1}, 64'h0);
        chk("reset.adc_sdata", {63'b0, sdata1}, 64'h0);
        chk("reset.adc_reset", {63'b0, reset1}, 64'h0);
        chk("reset.busy", {63'b0, busy1}, 64'h0);
        chk("reset.done", {63'b0, done1}, 64'h0);
        chk("reset.rd_valid", {63'b0, rd_valid1}, 64'h0);
        chk("reset.rd_data", {48'b0, rd_data1}, 64'h0);
        chk("reset.tbl_idx", {56'b0, tbl_idx1}, 64'h0);
        chk("reset.wr_ready", {63'b0, wr_ready1}, 64'h0);
        chk("reset.fast_idle", {busy2, done2, reset2, wr_ready2, rd_valid2, sclk2, sdata2, sen2,
                                tbl_idx2, rd_data2, 33'b0}, {7'b0, 2'b11, 8'h00, 16'h0000, 33'b0});
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            check_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].mask, vecs[i].word,
                        vecs[i].resp, vecs[i].cyc, vecs[i].lo0, vecs[i].lo1, vecs[i].rx,
                        vecs[i].rd);

        // Randomized host writes against the frame model.
        for (int i = 0; i < 10; i++) begin
            sel  = 1'($urandom_range(0, 1));
            mask = 2'($urandom_range(0, 3));
            word = 24'($urandom);
            resp = 24'($urandom);
            h    = sel ? 1 : 4;
            check_frame($sformatf("rand%0d", i), sel, mask, word, resp,
                        (mask != 2'b00) ? 52 * h : 0, mask[0] ? 50 * h : 0,
                        mask[1] ? 50 * h : 0, (mask != 2'b00) ? word : 24'h0, resp[15:0]);
        end

        // Full init sequence.
        use2 = 1'b0;
        run_init(-10, rst_hi, nframes, both_lo, sen_bad, ready_cnt, done_e);
        chk("init.reset_high", 64'(rst_hi), 64'd40);
        chk("init.frames", 64'(nframes), 64'd4);
        chk("init.both_sen_low", 64'(both_lo), 64'd800);
        chk("init.single_sen", 64'(sen_bad), 64'd0);
        chk("init.ready_while_busy", 64'(ready_cnt), 64'd0);
        chk("init.done_time", 64'(done_e), 64'd1076);
        for (int i = 0; i < 4; i++)
            chk($sformatf("init.frame%0d", i), {40'b0, init_rx[i]},
                {40'b0, 8'(8'h10 + i), 16'(16'hA5A0 + i)});
        @(negedge clk);
        chk("init.done_single", {63'b0, done1}, 64'h0);
        chk("init.idx_cleared", {56'b0, tbl_idx1}, 64'h0);
        chk("init.idle_after", {63'b0, busy1}, 64'h0);

        // Abort with rst at bit 10 of the second init frame.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int e = 0; e < 534; e++) begin
            @(negedge clk);
            if (e == 0) start = 1'b0;
        end
        chk("abort.pre_sen", {62'b0, sen1}, 64'h0);
        chk("abort.pre_idx", {56'b0, tbl_idx1}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.spi_idle", {61'b0, sen1, sclk1}, {61'b0, 2'b11, 1'b0});
        chk("abort.reset_busy", {62'b0, reset1, busy1}, 64'h0);
        chk("abort.wr_ready", {63'b0, wr_ready1}, 64'h0);
        rst = 1'b0;
        dcnt = 0;
        bcnt = 0;
        for (int e = 0; e < 1200; e++) begin
            @(negedge clk);
            if (done1) dcnt++;
            if (busy1 || rd_valid1) bcnt++;
        end
        chk("abort.no_done", 64'(dcnt), 64'd0);
        chk("abort.stays_idle", 64'(bcnt), 64'd0);
        run_init(-10, rst_hi, nframes, both_lo, sen_bad, ready_cnt, done_e);
        chk("restart.done_time", 64'(done_e), 64'd1076);
        chk("restart.frames", 64'(nframes), 64'd4);

        // start and wr_req together: start wins, the held write runs after init.
        wr_chip_mask = 2'b01;
        wr_word      = 24'h0A1234;
        wr_req       = 1'b1;
        run_init(600, rst_hi, nframes, both_lo, sen_bad, ready_cnt, done_e);
        chk("collide.ready_while_busy", 64'(ready_cnt), 64'd0);
        chk("collide.done_time", 64'(done_e), 64'd1076);
        chk("collide.frames", 64'(nframes), 64'd4);
        check_frame("collide.host", 1'b0, 2'b01, 24'h0A1234, 24'h00BEEF, 208, 200, 0,
                    24'h0A1234, 16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
